// File: rtl/tsc_control_unit_pkg.sv
// tsc_control_unit_pkg: opcode, func, ALU operation, state and select encodings for the TSC control unit
package tsc_control_unit_pkg;
  localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_BGZ = 4'd2, OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6, OP_LWD = 4'd7, OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9, OP_JAL = 4'd10, OP_RTYPE = 4'd15;
  localparam logic [5:0] FN_ADD = 6'd0, FN_SUB = 6'd1, FN_AND = 6'd2, FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4, FN_TCP = 6'd5, FN_SHL = 6'd6, FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25, FN_JRL = 6'd26, FN_WWD = 6'd28, FN_HLT = 6'd29;
  localparam logic [3:0] ALUOP_NONE = 4'd0, ALUOP_ADD = 4'd1, ALUOP_SUB = 4'd2, ALUOP_AND = 4'd3;
  localparam logic [3:0] ALUOP_ORR = 4'd4, ALUOP_NOT = 4'd5, ALUOP_TCP = 4'd6, ALUOP_SHL = 4'd7;
  localparam logic [3:0] ALUOP_SHR = 4'd8, ALUOP_ORI = 4'd9, ALUOP_LHI = 4'd10;
  localparam logic [3:0] ALUOP_BNE = 4'd11, ALUOP_BEQ = 4'd12, ALUOP_BGZ = 4'd13, ALUOP_BLZ = 4'd14;
  localparam logic [1:0] SRCB_REGB = 2'd0, SRCB_ONE = 2'd1, SRCB_SEXT = 2'd2, SRCB_ZEXT = 2'd3;
  localparam logic [1:0] PCSRC_ALU = 2'd0, PCSRC_ALUOUT = 2'd1, PCSRC_JUMP = 2'd2, PCSRC_REGA = 2'd3;
  localparam logic [1:0] WBSRC_ALUOUT = 2'd0, WBSRC_MDR = 2'd1, WBSRC_PC = 2'd2;
  localparam logic [1:0] REGDST_RT = 2'd0, REGDST_RD = 2'd1, REGDST_R2 = 2'd2;
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [3:0] {
    C_RALU, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JREG, C_WWD, C_HLT, C_ILLEGAL
  } class_e;
endpackage

// File: rtl/tsc_inst_class.sv
// tsc_inst_class: maps the latched opcode/func to an instruction class and its EX-stage ALU operation
module tsc_inst_class
  import tsc_control_unit_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic [5:0] i_func_code,
  output class_e     o_cls,
  output logic [3:0] o_ex_aluop,
  output logic       o_link
);
  // branch ALU ops follow opcode order and R-type ALU ops follow func order, so both are offsets
  always_comb begin
    o_cls = C_ILLEGAL;
    o_ex_aluop = ALUOP_NONE;
    o_link = (i_opcode == OP_JAL) || (i_opcode == OP_RTYPE && i_func_code == FN_JRL);
    case (i_opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
        o_cls = C_BRANCH;
        o_ex_aluop = ALUOP_BNE + i_opcode;
      end
      OP_ADI: begin
        o_cls = C_IALU;
        o_ex_aluop = ALUOP_ADD;
      end
      OP_ORI: begin
        o_cls = C_IALU;
        o_ex_aluop = ALUOP_ORI;
      end
      OP_LHI: begin
        o_cls = C_IALU;
        o_ex_aluop = ALUOP_LHI;
      end
      OP_LWD: begin
        o_cls = C_LOAD;
        o_ex_aluop = ALUOP_ADD;
      end
      OP_SWD: begin
        o_cls = C_STORE;
        o_ex_aluop = ALUOP_ADD;
      end
      OP_JMP, OP_JAL: o_cls = C_JUMP;
      OP_RTYPE: begin
        if (i_func_code[5:3] == 3'd0) begin
          o_cls = C_RALU;
          o_ex_aluop = ALUOP_ADD + {1'b0, i_func_code[2:0]};
        end else begin
          o_cls = (i_func_code == FN_JPR || i_func_code == FN_JRL) ? C_JREG :
                  (i_func_code == FN_WWD) ? C_WWD :
                  (i_func_code == FN_HLT) ? C_HLT : C_ILLEGAL;
        end
      end
      default: o_cls = C_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/tsc_control_unit.sv
// tsc_control_unit: multi-cycle control FSM of the 16-bit TSC core
module tsc_control_unit
  import tsc_control_unit_pkg::*;
#(
  parameter state_e RESET_STATE = S_IF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [5:0] func_code,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic [3:0] ALUOp,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_src,
  output logic       wwd,
  output logic       inst_done,
  output logic       halted
);
  state_e     r_state;
  state_e     w_next;
  class_e     w_cls;
  logic [3:0] w_ex_aluop;
  logic       w_link;
  tsc_inst_class u_class (
    .i_opcode    (opcode),
    .i_func_code (func_code),
    .o_cls       (w_cls),
    .o_ex_aluop  (w_ex_aluop),
    .o_link      (w_link)
  );
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= RESET_STATE;
    else r_state <= w_next;
  end
  // next state and datapath strobes; reset holds every strobe and select at zero
  always_comb begin
    w_next = r_state;
    ALUOp = ALUOP_NONE;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REGB;
    pc_write = 1'b0;
    pc_src = PCSRC_ALU;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    reg_dst = REGDST_RT;
    wb_src = WBSRC_ALUOUT;
    wwd = 1'b0;
    inst_done = 1'b0;
    halted = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
          ALUOp = mem_ready ? ALUOP_ADD : ALUOP_NONE;
          alu_src_b = mem_ready ? SRCB_ONE : SRCB_REGB;
          w_next = mem_ready ? S_ID : S_IF;
        end
        S_ID: begin
          ALUOp = ALUOP_ADD;
          alu_src_b = SRCB_SEXT;
          pc_write = w_cls inside {C_JUMP, C_JREG};
          pc_src = (w_cls == C_JREG) ? PCSRC_REGA : (w_cls == C_JUMP) ? PCSRC_JUMP : PCSRC_ALU;
          reg_write = w_link;
          reg_dst = w_link ? REGDST_R2 : REGDST_RT;
          wb_src = w_link ? WBSRC_PC : WBSRC_ALUOUT;
          wwd = (w_cls == C_WWD);
          inst_done = w_cls inside {C_JUMP, C_JREG, C_WWD, C_ILLEGAL};
          w_next = (w_cls inside {C_JUMP, C_JREG, C_WWD, C_ILLEGAL}) ? S_IF :
                   (w_cls == C_HLT) ? S_HALT : S_EX;
        end
        S_EX: begin
          alu_src_a = 1'b1;
          ALUOp = w_ex_aluop;
          alu_src_b = (w_cls inside {C_RALU, C_BRANCH}) ? SRCB_REGB :
                      (w_cls == C_IALU && opcode != OP_ADI) ? SRCB_ZEXT : SRCB_SEXT;
          pc_src = (w_cls == C_BRANCH) ? PCSRC_ALUOUT : PCSRC_ALU;
          pc_write = (w_cls == C_BRANCH) && branch_cond;
          inst_done = (w_cls == C_BRANCH);
          w_next = (w_cls == C_BRANCH) ? S_IF : (w_cls inside {C_LOAD, C_STORE}) ? S_MEM : S_WB;
        end
        S_MEM: begin
          i_or_d = 1'b1;
          mem_read = (w_cls == C_LOAD);
          mem_write = (w_cls == C_STORE);
          inst_done = (w_cls == C_STORE) && mem_ready;
          w_next = !mem_ready ? S_MEM : (w_cls == C_STORE) ? S_IF : S_WB;
        end
        S_WB: begin
          reg_write = 1'b1;
          inst_done = 1'b1;
          reg_dst = (w_cls == C_RALU) ? REGDST_RD : REGDST_RT;
          wb_src = (w_cls == C_LOAD) ? WBSRC_MDR : WBSRC_ALUOUT;
          w_next = S_IF;
        end
        S_HALT: halted = 1'b1;
        default: w_next = S_IF;
      endcase
    end
  end
endmodule

// File: tb/tb_tsc_control_unit.sv
// tb_tsc_control_unit: randomized bench checking every cycle against a per-instruction phase-plan model
module tb_tsc_control_unit;
  import tsc_control_unit_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = '0;
  logic [5:0] func_code = '0;
  logic       branch_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] ALUOp;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, wb_src;
  logic       wwd, inst_done, halted;
  typedef struct packed {
    logic [3:0] aluop;
    logic       src_a;
    logic [1:0] src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, wb_src;
    logic       wwd, done, halted;
  } ctl_t;
  typedef enum {P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_HALT} phase_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  phase_e     plan[$];
  ctl_t       trace[$];
  logic [3:0] cur_op = '0, next_op = '0;
  logic [5:0] cur_fn = '0, next_fn = '0;
  logic [3:0] ex_op[string];
  ctl_t       act;
  assign act = {ALUOp, alu_src_a, alu_src_b, pc_write, pc_src, i_or_d, mem_read, mem_write,
                ir_write, reg_write, reg_dst, wb_src, wwd, inst_done, halted};
  always #5 clk = ~clk;
  tsc_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
    .branch_cond(branch_cond), .mem_ready(mem_ready), .ALUOp(ALUOp),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_write(pc_write), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src), .wwd(wwd),
    .inst_done(inst_done), .halted(halted)
  );

  function automatic string mnem(input logic [3:0] op, input logic [5:0] fn);
    string m;
    m = "ILL";
    case (op)
      4'd0: m = "BNE";
      4'd1: m = "BEQ";
      4'd2: m = "BGZ";
      4'd3: m = "BLZ";
      4'd4: m = "ADI";
      4'd5: m = "ORI";
      4'd6: m = "LHI";
      4'd7: m = "LWD";
      4'd8: m = "SWD";
      4'd9: m = "JMP";
      4'd10: m = "JAL";
      4'd15: case (fn)
        6'd0: m = "ADD";
        6'd1: m = "SUB";
        6'd2: m = "AND";
        6'd3: m = "ORR";
        6'd4: m = "NOT";
        6'd5: m = "TCP";
        6'd6: m = "SHL";
        6'd7: m = "SHR";
        6'd25: m = "JPR";
        6'd26: m = "JRL";
        6'd28: m = "WWD";
        6'd29: m = "HLT";
        default: m = "ILL";
      endcase
      default: m = "ILL";
    endcase
    return m;
  endfunction

  function automatic bit is_branch(input string m);
    return m == "BNE" || m == "BEQ" || m == "BGZ" || m == "BLZ";
  endfunction

  function automatic bit ends_in_decode(input string m);
    return m == "JMP" || m == "JAL" || m == "JPR" || m == "JRL" || m == "WWD" || m == "ILL";
  endfunction

  function automatic ctl_t expect_ctl(input phase_e p, input logic [3:0] op, input logic [5:0] fn,
                                      input logic rdy, input logic bc);
    ctl_t  e;
    string m;
    bit    r, br;
    e = '0;
    m = mnem(op, fn);
    r = (op == 4'd15) && ex_op.exists(m);
    br = is_branch(m);
    case (p)
      P_FETCH: begin
        e.mem_read = 1'b1;
        if (rdy) begin
          e.ir_write = 1'b1;
          e.pc_write = 1'b1;
          e.aluop = ALUOP_ADD;
          e.src_b = SRCB_ONE;
        end
      end
      P_DECODE: begin
        e.aluop = ALUOP_ADD;
        e.src_b = SRCB_SEXT;
        if (m == "JMP" || m == "JAL") begin
          e.pc_write = 1'b1;
          e.pc_src = PCSRC_JUMP;
        end
        if (m == "JPR" || m == "JRL") begin
          e.pc_write = 1'b1;
          e.pc_src = PCSRC_REGA;
        end
        if (m == "JAL" || m == "JRL") begin
          e.reg_write = 1'b1;
          e.reg_dst = REGDST_R2;
          e.wb_src = WBSRC_PC;
        end
        e.wwd = (m == "WWD");
        e.done = ends_in_decode(m);
      end
      P_EXEC: begin
        e.src_a = 1'b1;
        e.aluop = ex_op[m];
        e.src_b = (r || br) ? SRCB_REGB : (m == "ORI" || m == "LHI") ? SRCB_ZEXT : SRCB_SEXT;
        if (br) begin
          e.pc_src = PCSRC_ALUOUT;
          e.pc_write = bc;
          e.done = 1'b1;
        end
      end
      P_MEM: begin
        e.i_or_d = 1'b1;
        e.mem_read = (m == "LWD");
        e.mem_write = (m == "SWD");
        e.done = (m == "SWD") && rdy;
      end
      P_WB: begin
        e.reg_write = 1'b1;
        e.done = 1'b1;
        e.reg_dst = r ? REGDST_RD : REGDST_RT;
        e.wb_src = (m == "LWD") ? WBSRC_MDR : WBSRC_ALUOUT;
      end
      default: e.halted = 1'b1;
    endcase
    return e;
  endfunction

  task automatic load_plan(input string m);
    plan = {};
    plan.push_back(P_DECODE);
    if (m == "HLT") plan.push_back(P_HALT);
    else if (!ends_in_decode(m)) begin
      plan.push_back(P_EXEC);
      if (m == "LWD" || m == "SWD") plan.push_back(P_MEM);
      if (!is_branch(m) && m != "SWD") plan.push_back(P_WB);
    end
    if (m != "HLT") plan.push_back(P_FETCH);
  endtask

  task automatic chk(input string name, input int act_v, input int exp_v);
    n_cmp++;
    if (act_v != exp_v) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act_v, exp_v);
    end
  endtask

  task automatic tick(input logic rdy, input logic bc, input logic rst);
    phase_e p;
    ctl_t   e;
    p = plan[0];
    reset = rst;
    mem_ready = rdy;
    branch_cond = bc;
    opcode = (p == P_FETCH) ? 4'($urandom) : cur_op;
    func_code = (p == P_FETCH) ? 6'($urandom) : cur_fn;
    #2;
    e = rst ? ctl_t'(0) : expect_ctl(p, cur_op, cur_fn, rdy, bc);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL ctl t=%0t phase=%s inst=%s rdy=%0b bc=%0b rst=%0b actual=%h required=%h",
               $time, p.name(), mnem(cur_op, cur_fn), rdy, bc, rst, act, e);
    end
    n_cmp++;
    if ((mem_read && mem_write) || (reg_write && mem_write)) begin
      n_bad++;
      $display("FAIL exclusive_strobes t=%0t actual rd=%0b wr=%0b rw=%0b required no overlap",
               $time, mem_read, mem_write, reg_write);
    end
    trace.push_back(act);
    if (rst) plan = {P_FETCH};
    else if (p == P_FETCH) begin
      if (rdy) begin
        cur_op = next_op;
        cur_fn = next_fn;
        load_plan(mnem(cur_op, cur_fn));
      end
    end else if (p == P_MEM) begin
      if (rdy) void'(plan.pop_front());
    end else if (p != P_HALT) void'(plan.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic exec_inst(input logic [3:0] op, input logic [5:0] fn, input int s_if,
                           input int s_mem, input logic bc, output int cycles, output int dones);
    int     k_if, k_mem;
    bit     fetched, ended;
    phase_e p;
    logic   rdy;
    k_if = 0;
    k_mem = 0;
    fetched = 0;
    ended = 0;
    cycles = 0;
    dones = 0;
    next_op = op;
    next_fn = fn;
    trace = {};
    while (cycles < 60 && !ended) begin
      p = plan[0];
      if (p == P_FETCH) begin
        rdy = (k_if >= s_if);
        k_if++;
      end else if (p == P_MEM) begin
        rdy = (k_mem >= s_mem);
        k_mem++;
      end else rdy = 1'($urandom);
      if (p == P_FETCH && rdy) fetched = 1;
      tick(rdy, bc, 1'b0);
      cycles++;
      ended = fetched && (plan[0] == P_FETCH || plan[0] == P_HALT);
    end
    chk("inst_completes", int'(ended), 1);
    foreach (trace[i]) dones += int'(trace[i].done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc, dn, nh, nr;
    logic [3:0] op;
    logic [5:0] fn;
    logic [5:0] fns[12] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd25, 6'd26, 6'd28, 6'd29};
    ex_op["ADD"] = ALUOP_ADD; ex_op["SUB"] = ALUOP_SUB; ex_op["AND"] = ALUOP_AND;
    ex_op["ORR"] = ALUOP_ORR; ex_op["NOT"] = ALUOP_NOT; ex_op["TCP"] = ALUOP_TCP;
    ex_op["SHL"] = ALUOP_SHL; ex_op["SHR"] = ALUOP_SHR;
    ex_op["ADI"] = ALUOP_ADD; ex_op["ORI"] = ALUOP_ORI; ex_op["LHI"] = ALUOP_LHI;
    ex_op["LWD"] = ALUOP_ADD; ex_op["SWD"] = ALUOP_ADD;
    ex_op["BNE"] = ALUOP_BNE; ex_op["BEQ"] = ALUOP_BEQ; ex_op["BGZ"] = ALUOP_BGZ; ex_op["BLZ"] = ALUOP_BLZ;
    plan = {P_FETCH};
    @(posedge clk);
    #1;
    trace = {};
    tick(1'b1, 1'b1, 1'b1);
    chk("rst_mem_read", int'(trace[0].mem_read), 0);
    chk("rst_aluop", int'(trace[0].aluop), 0);
    exec_inst(4'd15, 6'd0, 0, 0, 1'b0, cyc, dn);
    chk("add_cycles", cyc, 4);
    chk("add_done", dn, 1);
    chk("add_ex_aluop", int'(trace[2].aluop), 1);
    chk("add_ex_srcb", int'(trace[2].src_b), 0);
    chk("add_id_regwrite", int'(trace[1].reg_write), 0);
    chk("add_wb_regwrite", int'(trace[3].reg_write), 1);
    chk("add_wb_regdst", int'(trace[3].reg_dst), 1);
    exec_inst(4'd7, 6'($urandom), 0, 2, 1'b0, cyc, dn);
    chk("lwd_cycles", cyc, 7);
    for (int i = 3; i < 6; i++) chk("lwd_mem_rd_iod", int'(trace[i].mem_read & trace[i].i_or_d), 1);
    chk("lwd_wb_src", int'(trace[6].wb_src), 1);
    chk("lwd_wb_regwrite", int'(trace[6].reg_write), 1);
    for (int b = 1; b >= 0; b--) begin
      exec_inst(4'd1, 6'($urandom), 0, 0, 1'(b), cyc, dn);
      chk("beq_cycles", cyc, 3);
      chk("beq_aluop", int'(trace[2].aluop), 12);
      chk("beq_pc_src", int'(trace[2].pc_src), 1);
      chk("beq_pc_write", int'(trace[2].pc_write), b);
      chk("beq_done_c3", int'(trace[2].done), 1);
    end
    exec_inst(4'd10, 6'($urandom), 1, 0, 1'b0, cyc, dn);
    chk("jal_cycles", cyc, 3);
    chk("jal_id_fields", int'({trace[2].reg_write, trace[2].reg_dst, trace[2].wb_src,
                               trace[2].pc_write, trace[2].pc_src}), 'b1_10_10_1_10);
    exec_inst(4'd15, 6'd29, 0, 0, 1'b0, cyc, dn);
    chk("hlt_cycles", cyc, 2);
    chk("hlt_no_done", dn, 0);
    trace = {};
    repeat (20) tick(1'($urandom), 1'($urandom), 1'b0);
    nh = 0;
    nr = 0;
    foreach (trace[i]) begin
      nh += int'(trace[i].halted);
      nr += int'(trace[i].mem_read);
    end
    chk("hlt_halted_20", nh, 20);
    chk("hlt_no_mem_read", nr, 0);
    tick(1'b1, 1'b0, 1'b1);
    trace = {};
    tick(1'b0, 1'b0, 1'b0);
    chk("hlt_reset_if_read", int'(trace[0].mem_read), 1);
    chk("hlt_reset_unhalt", int'(trace[0].halted), 0);
    next_op = 4'd8;
    next_fn = 6'd0;
    trace = {};
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("swd_stall_write", int'(trace[3].mem_write), 1);
    tick(1'b0, 1'b0, 1'b1);
    chk("swd_reset_no_write", int'(trace[4].mem_write), 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("swd_after_reset_if", int'({trace[5].mem_read, trace[5].i_or_d}), 2);
    dn = 0;
    foreach (trace[i]) dn += int'(trace[i].done);
    chk("swd_abort_no_done", dn, 0);
    repeat (300) begin
      op = 4'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 11)];
      exec_inst(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), cyc, dn);
      chk("retire_once", dn, (mnem(op, fn) == "HLT") ? 0 : 1);
      if (plan[0] == P_HALT || $urandom_range(0, 15) == 0) tick(1'($urandom), 1'($urandom), 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
